encryption_stream: RTL



---
 rtl/encryption_stream.sv | 73 +++++++
 1 files changed

// File: rtl/encryption_stream.sv
// Transmit-side byte encrypter: e = ROTL5(REV(NOT(ROTR5(data ^ key)))) through a
// 5-stage stallable pipeline, with frame counting on the output handshake.
module encryption_stream #(
  parameter int N           = 8,
  parameter int FRAME_BYTES = 32,
  parameter int CW          = $clog2(FRAME_BYTES)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  key,
  input  logic [N-1:0]  data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  e_data,
  output logic          out_last,
  output logic [CW-1:0] frame_cnt
);

  logic [N-1:0] s1_data, s2_data, s3_data, s4_data, s5_data;
  logic [4:0]   s_valid;
  logic         adv;

  function automatic logic [N-1:0] rotr5(input logic [N-1:0] x);
    return {x[4:0], x[N-1:5]};
  endfunction

  function automatic logic [N-1:0] rotl5(input logic [N-1:0] x);
    return {x[N-6:0], x[N-1:N-5]};
  endfunction

  function automatic logic [N-1:0] bit_rev(input logic [N-1:0] x);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = x[N-1-i];
    return r;
  endfunction

  // Whole pipeline moves as one; bubbles shift along rather than being squeezed out.
  assign adv       = !s_valid[4] || out_ready;
  assign in_ready  = adv;
  assign e_data    = s5_data;
  assign out_valid = s_valid[4];
  assign out_last  = out_valid && (frame_cnt == CW'(FRAME_BYTES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      s_valid <= '0;
      s1_data <= '0;
      s2_data <= '0;
      s3_data <= '0;
      s4_data <= '0;
      s5_data <= '0;
    end else if (adv) begin
      s_valid <= {s_valid[3:0], in_valid};
      if (in_valid) s1_data <= data ^ key;
      s2_data <= rotr5(s1_data);
      s3_data <= ~s2_data;
      s4_data <= bit_rev(s3_data);
      s5_data <= rotl5(s4_data);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (frame_cnt == CW'(FRAME_BYTES - 1)) frame_cnt <= '0;
      else                                   frame_cnt <= frame_cnt + CW'(1);
    end
  end

endmodule
